// File: rtl/osc_phase_decoder_if.sv
// Bus bundle for osc_phase_decoder: phase inputs, start handshake and measurement results.
interface osc_phase_decoder_if #(
    parameter int CNT_W = 16
);
    logic             ph_a;
    logic             ph_b;
    logic             ph_c;
    logic             ph_d;
    logic             ph_e;
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sector_count;
    logic [CNT_W-1:0] period_count;
    logic [3:0]       phase;
    logic             phase_valid;
    logic             err_code;
    logic             err_step;
    logic             ovf;

    modport master (
        output ph_a, ph_b, ph_c, ph_d, ph_e, start,
        input  busy, done, sector_count, period_count, phase, phase_valid,
               err_code, err_step, ovf
    );

    modport slave (
        input  ph_a, ph_b, ph_c, ph_d, ph_e, start,
        output busy, done, sector_count, period_count, phase, phase_valid,
               err_code, err_step, ovf
    );
endinterface

// File: rtl/osc_phase_decoder.sv
// Decodes the five oscillator phases into a 10-sector index and measures sector/period
// advance over a fixed window of clk cycles.
//
// state  | meaning
// IDLE   | waiting for start, results of the last window held
// RUN    | window open, accumulating accepted sector steps
// DONE   | one-cycle result strobe, start accepted here too
module osc_phase_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int WINDOW      = 1024,
    parameter int CNT_W       = 16,
    parameter int MAX_STEP    = 4
) (
    input logic               clk,
    input logic               rst,
    osc_phase_decoder_if.slave bus
);

    localparam int WIN_W = $clog2(WINDOW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
    logic [3:0]       phase_q, phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] sector_count_q, sector_count_d;
    logic [CNT_W-1:0] period_count_q, period_count_d;
    logic             err_code_q, err_code_d;
    logic             err_step_q, err_step_d;
    logic             ovf_q, ovf_d;

    logic             dec_legal;
    logic [3:0]       dec_sector;
    logic [3:0]       delta_raw;
    logic             take_delta;
    logic             step_ok;
    logic             step_bad;
    logic [3:0]       acc_delta;
    logic             wrap;
    logic [CNT_W:0]   sec_sum;
    logic             launch;

    function automatic logic [4:0] decode(input logic [4:0] code);
        case (code)
            5'b11010: decode = {1'b1, 4'd0};
            5'b10010: decode = {1'b1, 4'd1};
            5'b10110: decode = {1'b1, 4'd2};
            5'b10100: decode = {1'b1, 4'd3};
            5'b10101: decode = {1'b1, 4'd4};
            5'b00101: decode = {1'b1, 4'd5};
            5'b01101: decode = {1'b1, 4'd6};
            5'b01001: decode = {1'b1, 4'd7};
            5'b01011: decode = {1'b1, 4'd8};
            5'b01010: decode = {1'b1, 4'd9};
            default:  decode = {1'b0, 4'd0};
        endcase
    endfunction

    always_comb begin
        sync_d[0] = {bus.ph_a, bus.ph_b, bus.ph_c, bus.ph_d, bus.ph_e};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // The held phase is always a legal sector, so a step resuming after an
    // illegal stretch is still judged against it.
    always_comb begin
        {dec_legal, dec_sector} = decode(sync_q[SYNC_STAGES-1]);
        if (dec_sector >= phase_q) begin
            delta_raw = dec_sector - phase_q;
        end else begin
            delta_raw = dec_sector + 4'd10 - phase_q;
        end
        take_delta    = dec_legal && phase_valid_q;
        step_ok       = take_delta && (delta_raw <= 4'(MAX_STEP));
        step_bad      = take_delta && !step_ok;
        acc_delta     = step_ok ? delta_raw : 4'd0;
        wrap          = step_ok && (({1'b0, phase_q} + {1'b0, delta_raw}) >= 5'd10);
        sec_sum       = {1'b0, sector_count_q} + {{(CNT_W-3){1'b0}}, acc_delta};
        phase_d       = dec_legal ? dec_sector : phase_q;
        phase_valid_d = phase_valid_q | dec_legal;
    end

    always_comb begin
        state_d        = state_q;
        win_cnt_d      = win_cnt_q;
        sector_count_d = sector_count_q;
        period_count_d = period_count_q;
        err_code_d     = err_code_q;
        err_step_d     = err_step_q;
        ovf_d          = ovf_q;
        launch         = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
            end
            S_RUN: begin
                if (!dec_legal) err_code_d = 1'b1;
                if (step_bad)   err_step_d = 1'b1;
                if (sec_sum[CNT_W]) begin
                    sector_count_d = '1;
                    ovf_d          = 1'b1;
                end else begin
                    sector_count_d = sec_sum[CNT_W-1:0];
                end
                if (wrap) begin
                    if (&period_count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        period_count_d = period_count_q + CNT_W'(1);
                    end
                end
                win_cnt_d = win_cnt_q - WIN_W'(1);
                if (win_cnt_q == WIN_W'(1)) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d        = S_RUN;
            win_cnt_d      = WIN_W'(WINDOW);
            sector_count_d = '0;
            period_count_d = '0;
            err_code_d     = 1'b0;
            err_step_d     = 1'b0;
            ovf_d          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q         <= '0;
            phase_q        <= '0;
            phase_valid_q  <= 1'b0;
            state_q        <= S_IDLE;
            win_cnt_q      <= '0;
            sector_count_q <= '0;
            period_count_q <= '0;
            err_code_q     <= 1'b0;
            err_step_q     <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            phase_q        <= phase_d;
            phase_valid_q  <= phase_valid_d;
            state_q        <= state_d;
            win_cnt_q      <= win_cnt_d;
            sector_count_q <= sector_count_d;
            period_count_q <= period_count_d;
            err_code_q     <= err_code_d;
            err_step_q     <= err_step_d;
            ovf_q          <= ovf_d;
        end
    end

    assign bus.busy         = (state_q == S_RUN);
    assign bus.done         = (state_q == S_DONE);
    assign bus.sector_count = sector_count_q;
    assign bus.period_count = period_count_q;
    assign bus.phase        = phase_q;
    assign bus.phase_valid  = phase_valid_q;
    assign bus.err_code     = err_code_q;
    assign bus.err_step     = err_step_q;
    assign bus.ovf          = ovf_q;

endmodule

// File: tb/tb_osc_phase_decoder.sv
// Directed bench for osc_phase_decoder: decode table, window measurements on three
// parameterisations (W25, W16 back-to-back, W20 with 4-bit counters), errors and reset.
module tb_osc_phase_decoder;

    logic clk;
    logic rst;
    logic [4:0] ph_code;
    logic start_v [3];

    logic        busy_v  [3];
    logic        done_v  [3];
    logic [15:0] sc_v    [3];
    logic [15:0] pc_v    [3];
    logic [3:0]  ph_v    [3];
    logic        valid_v [3];
    logic        ec_v    [3];
    logic        es_v    [3];
    logic        ov_v    [3];

    int checks   = 0;
    int failures = 0;

    logic [4:0] enc [10];

    typedef struct {
        logic [4:0] code;
        int         exp_phase;
    } dec_vec_t;

    typedef struct {
        int   dut;
        int   mode;
        int   win;
        int   restart;
        int   exp_sc;
        int   exp_pc;
        int   exp_ec;
        int   exp_es;
        int   exp_ov;
    } win_vec_t;

    dec_vec_t dvec [14];
    win_vec_t wvec [5];

    osc_phase_decoder_if #(.CNT_W(16)) if_a ();
    osc_phase_decoder_if #(.CNT_W(16)) if_b ();
    osc_phase_decoder_if #(.CNT_W(4))  if_c ();

    osc_phase_decoder #(.SYNC_STAGES(2), .WINDOW(25), .CNT_W(16), .MAX_STEP(4))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    osc_phase_decoder #(.SYNC_STAGES(2), .WINDOW(16), .CNT_W(16), .MAX_STEP(4))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    osc_phase_decoder #(.SYNC_STAGES(2), .WINDOW(20), .CNT_W(4), .MAX_STEP(4))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    assign {if_a.ph_a, if_a.ph_b, if_a.ph_c, if_a.ph_d, if_a.ph_e} = ph_code;
    assign {if_b.ph_a, if_b.ph_b, if_b.ph_c, if_b.ph_d, if_b.ph_e} = ph_code;
    assign {if_c.ph_a, if_c.ph_b, if_c.ph_c, if_c.ph_d, if_c.ph_e} = ph_code;
    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];

    assign busy_v[0] = if_a.busy;  assign busy_v[1] = if_b.busy;  assign busy_v[2] = if_c.busy;
    assign done_v[0] = if_a.done;  assign done_v[1] = if_b.done;  assign done_v[2] = if_c.done;
    assign sc_v[0] = if_a.sector_count;
    assign sc_v[1] = if_b.sector_count;
    assign sc_v[2] = {12'd0, if_c.sector_count};
    assign pc_v[0] = if_a.period_count;
    assign pc_v[1] = if_b.period_count;
    assign pc_v[2] = {12'd0, if_c.period_count};
    assign ph_v[0] = if_a.phase;   assign ph_v[1] = if_b.phase;   assign ph_v[2] = if_c.phase;
    assign valid_v[0] = if_a.phase_valid;
    assign valid_v[1] = if_b.phase_valid;
    assign valid_v[2] = if_c.phase_valid;
    assign ec_v[0] = if_a.err_code; assign ec_v[1] = if_b.err_code; assign ec_v[2] = if_c.err_code;
    assign es_v[0] = if_a.err_step; assign es_v[1] = if_b.err_step; assign es_v[2] = if_c.err_step;
    assign ov_v[0] = if_a.ovf;     assign ov_v[1] = if_b.ovf;     assign ov_v[2] = if_c.ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Phase code seen at step i of a stimulus pattern.
    function automatic logic [4:0] stim(input int mode, input int i);
        logic [4:0] c;
        case (mode)
            0: c = enc[i % 10];
            1: c = enc[(2 * i) % 10];
            2: c = ((i >= 10 && i <= 12) || (i >= 17 && i <= 20)) ? 5'b11111 : enc[i % 10];
            default: c = (i < 5) ? enc[0] : ((i < 9) ? enc[5] : enc[3]);
        endcase
        return c;
    endfunction

    task automatic run_window(input win_vec_t v, input int n);
        int first_done  = 0;
        int second_done = 0;
        int done_cnt    = 0;
        int busy_after  = 0;
        int sc1 = 0, pc1 = 0, ec1 = 0, es1 = 0, ov1 = 0;
        int exp_done = v.win + 3;
        ph_code = enc[0];
        repeat (6) @(negedge clk);
        for (int i = 1; i <= 2 * v.win + 25; i++) begin
            @(negedge clk);
            if (done_v[v.dut]) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done = i;
                    sc1 = int'(sc_v[v.dut]);
                    pc1 = int'(pc_v[v.dut]);
                    ec1 = int'(ec_v[v.dut]);
                    es1 = int'(es_v[v.dut]);
                    ov1 = int'(ov_v[v.dut]);
                end else if (second_done == 0) begin
                    second_done = i;
                end
            end
            if (i == exp_done + 1) busy_after = int'(busy_v[v.dut]);
            if (v.mode == 2 && i == 14) begin
                check($sformatf("w%0d_phase_held", n), int'(ph_v[v.dut]), 9);
                check($sformatf("w%0d_err_code_mid", n), int'(ec_v[v.dut]), 1);
                check($sformatf("w%0d_err_step_mid", n), int'(es_v[v.dut]), 0);
            end
            if (v.mode == 3 && i == 9) begin
                check($sformatf("w%0d_phase_jump", n), int'(ph_v[v.dut]), 5);
                check($sformatf("w%0d_err_step_jump", n), int'(es_v[v.dut]), 1);
            end
            ph_code = stim(v.mode, i);
            start_v[v.dut] = (i == 2) || (v.restart != 0 && i == exp_done);
        end
        start_v[v.dut] = 1'b0;
        check($sformatf("w%0d_done_at", n), first_done, exp_done);
        check($sformatf("w%0d_sector", n), sc1, v.exp_sc);
        check($sformatf("w%0d_period", n), pc1, v.exp_pc);
        check($sformatf("w%0d_flags", n), ec1 * 4 + es1 * 2 + ov1,
              v.exp_ec * 4 + v.exp_es * 2 + v.exp_ov);
        if (v.restart != 0) begin
            check($sformatf("w%0d_busy_restart", n), busy_after, 1);
            check($sformatf("w%0d_done2_at", n), second_done, exp_done + v.win + 1);
            check($sformatf("w%0d_sector2", n), int'(sc_v[v.dut]), v.exp_sc);
            check($sformatf("w%0d_period2", n), int'(pc_v[v.dut]), v.exp_pc);
            check($sformatf("w%0d_done_count", n), done_cnt, 2);
        end else begin
            check($sformatf("w%0d_done_count", n), done_cnt, 1);
            check($sformatf("w%0d_busy_after", n), busy_after, 0);
        end
        if (v.mode == 3) check($sformatf("w%0d_phase_final", n), int'(ph_v[v.dut]), 3);
    endtask

    initial begin
        enc[0] = 5'b11010; enc[1] = 5'b10010; enc[2] = 5'b10110; enc[3] = 5'b10100;
        enc[4] = 5'b10101; enc[5] = 5'b00101; enc[6] = 5'b01101; enc[7] = 5'b01001;
        enc[8] = 5'b01011; enc[9] = 5'b01010;

        dvec[0]  = '{5'b11010, 0}; dvec[1]  = '{5'b10010, 1}; dvec[2]  = '{5'b10110, 2};
        dvec[3]  = '{5'b10100, 3}; dvec[4]  = '{5'b10101, 4}; dvec[5]  = '{5'b00101, 5};
        dvec[6]  = '{5'b11111, 5}; dvec[7]  = '{5'b01101, 6}; dvec[8]  = '{5'b01001, 7};
        dvec[9]  = '{5'b00000, 7}; dvec[10] = '{5'b01011, 8}; dvec[11] = '{5'b01010, 9};
        dvec[12] = '{5'b10000, 9}; dvec[13] = '{5'b11010, 0};

        //            dut mode win rst  sc  pc ec es ov
        wvec[0] = '{0,  0,  25, 0,  25, 2, 0, 0, 0};
        wvec[1] = '{2,  0,  20, 0,  15, 2, 0, 0, 1};
        wvec[2] = '{1,  1,  16, 1,  32, 3, 0, 0, 0};
        wvec[3] = '{0,  2,  25, 0,  20, 1, 1, 1, 0};
        wvec[4] = '{0,  3,  25, 0,   0, 0, 0, 1, 0};

        rst = 1'b1;
        ph_code = enc[0];
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        repeat (4) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_outputs_%0d", d),
                  int'(sc_v[d] | pc_v[d]) + int'(ph_v[d]) +
                  int'({busy_v[d], done_v[d], valid_v[d], ec_v[d], es_v[d], ov_v[d]}), 0);
        end

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("valid_before_latency", int'(valid_v[0]), 0);
        @(negedge clk);
        check("valid_at_latency", int'(valid_v[0]), 1);
        check("phase_at_latency", int'(ph_v[0]), 0);

        for (int k = 0; k < 14; k++) begin
            ph_code = dvec[k].code;
            repeat (4) @(negedge clk);
            check($sformatf("decode_%0d", k), int'(ph_v[0]), dvec[k].exp_phase);
        end
        check("decode_idle_flags", int'({busy_v[0], ec_v[0], es_v[0]}), 0);

        for (int k = 0; k < 5; k++) run_window(wvec[k], k);

        // Reset in the middle of a running window.
        begin
            int done_seen = 0;
            ph_code = enc[0];
            repeat (6) @(negedge clk);
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (done_v[0]) done_seen++;
                if (i == 8) check("rst_busy_before", int'(busy_v[0]), 1);
                if (i == 13) begin
                    check("rst_busy_after", int'(busy_v[0]), 0);
                    check("rst_sector_cleared", int'(sc_v[0]), 0);
                    check("rst_valid_cleared", int'(valid_v[0]), 0);
                end
                ph_code = stim(0, i);
                start_v[0] = (i == 2);
                rst = (i == 12);
            end
            rst = 1'b0;
            check("rst_no_done", done_seen, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/osc_phase_decoder.md
Name: osc_phase_decoder

Overview:
- Receiving end of the five-phase behavioural oscillator (outputs A–E, 0.1-period spacing, ctrl-selected period).
- Samples the five phases on a system clock and decodes them into a 10-sector phase index.
- Accumulates the phase advance over a programmable window and reports sector and whole-period counts.
- Gives the digital side a frequency measurement of the oscillator, against which the ctrl setting is checked.

Parameters:
SYNC_STAGES, 2, synchroniser flops per phase input (min 2)
WINDOW, 1024, measurement window length in clk cycles (min 1)
CNT_W, 16, width of sector_count and period_count
MAX_STEP, 4, largest forward sector step per clk accepted as valid (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ph_a  in  1  oscillator phase A (asynchronous)
ph_b  in  1  oscillator phase B (asynchronous)
ph_c  in  1  oscillator phase C (asynchronous)
ph_d  in  1  oscillator phase D (asynchronous)
ph_e  in  1  oscillator phase E (asynchronous)
start  in  1  single-cycle request to begin a measurement window
busy  out  1  window in progress
done  out  1  one-cycle pulse, results valid
sector_count  out  CNT_W  sectors (tenths of a period) advanced during the last window
period_count  out  CNT_W  whole periods completed during the last window (sector 9->0 crossings)
phase  out  4  current decoded sector 0..9
phase_valid  out  1  phase holds a sector decoded since reset
err_code  out  1  sticky: an illegal phase code was seen during the window
err_step  out  1  sticky: a step > MAX_STEP (or backward) was seen during the window
ovf  out  1  sticky: sector_count or period_count saturated

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, FSM in IDLE. Reset mid-window aborts it: no done, counts cleared.
- Each ph_* passes through SYNC_STAGES flops. The code {a,b,c,d,e} is then decoded and registered. Latency from input change to phase update is SYNC_STAGES+1 cycles.
- Decode table (abcde -> sector):
  - 11010->0, 10010->1, 10110->2, 10100->3, 10101->4
  - 00101->5, 01101->6, 01001->7, 01011->8, 01010->9
  - The other 22 codes are illegal: phase holds its last value, no delta is taken that cycle, err_code is set if busy.
- delta = (new_sector - prev_sector) mod 10, computed only when both the previous and current decodes are legal and phase_valid=1.
  - delta 0..MAX_STEP: accepted.
  - Otherwise (including 5..9, i.e. ambiguous or backward): rejected, err_step set if busy, phase still updates to the new sector.
- FSM states:
  - IDLE: start=1 -> RUN. On entry: clear counts and error flags; window counter = WINDOW; busy=1.
  - RUN: each cycle, add the accepted delta to sector_count. If prev_sector+delta >= 10, increment period_count. Decrement the window counter. The last of WINDOW cycles -> DONE.
  - DONE: done=1 for one cycle, busy=0, -> IDLE. start in the DONE cycle is accepted, so the next window begins the following cycle.
- The window covers exactly WINDOW cycles, starting the cycle after start is accepted. start while busy is ignored.
- Results and error flags hold from done until the next accepted start.
- Both counters saturate at 2^CNT_W-1 and set ovf, so they never wrap.
- The phase/phase_valid path runs continuously, independent of the FSM.

Test Plan:
- Reset, then phases held at 11010 for SYNC_STAGES+1 cycles -> phase=0, phase_valid=1; busy/done/counts/flags all 0.
- WINDOW=25, sector advances +1 every clk from baseline 0, start pulsed -> done 26 cycles after start; sector_count=25, period_count=2, no flags.
- WINDOW=16, sector advances +2 per clk from 0 -> sector_count=32, period_count=3. Start asserted in the done cycle -> new window begins immediately.
- Illegal code 11111 injected for 3 cycles mid-window, otherwise +1/clk -> err_code=1, phase held; those 3 cycles add nothing, and the resume step counts only if <= MAX_STEP, else err_step=1.
- Jump 0->5 while busy -> err_step=1, delta discarded, phase=5. Backward step 5->3 -> err_step stays 1.
- rst asserted mid-window -> next cycle busy=0, counts=0, no done pulse. CNT_W=4 with +1/clk over WINDOW=20 -> sector_count=15, ovf=1.
